// File: rtl/aes_block_assembler.sv
// aes_block_assembler: packs UART bytes into one plaintext block for the AES core.
// A partial block is dropped after an inter-byte timeout. A full block is held
// under a valid/ready handshake, and bytes that arrive meanwhile are dropped and flagged.
module aes_block_assembler #(
  parameter int unsigned BLOCK_BYTES  = 16,
  parameter int unsigned TIMEOUT_CLKS = 3480
) (
  input  logic                                 i_Clock,
  input  logic                                 i_Rst_n,
  input  logic                                 i_Clear,
  input  logic                                 i_Rx_DV,
  input  logic [7:0]                           i_Rx_Byte,
  output logic                                 o_Block_Valid,
  input  logic                                 i_Block_Ready,
  output logic [0:BLOCK_BYTES*8-1]             o_Block,
  output logic [$clog2(BLOCK_BYTES+1)-1:0]     o_Byte_Count,
  output logic                                 o_Timeout,
  output logic                                 o_Overrun
);

  localparam int unsigned CW = $clog2(BLOCK_BYTES + 1);
  localparam int unsigned TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  typedef enum logic [1:0] {StIdle, StFill, StFull} state_t;

  state_t                    r_state, w_state_d;
  logic [CW-1:0]             r_count, w_count_d;
  logic [TW-1:0]             r_timer, w_timer_d;
  logic [0:BLOCK_BYTES*8-1]  r_block, w_block_d;
  logic                      r_valid, r_timeout, r_overrun;
  logic                      w_timeout_d, w_overrun_d;
  logic                      w_wr_en;
  logic [CW-1:0]             w_wr_idx;

  // Next-state, byte-write and pulse decode.
  always_comb begin
    w_state_d   = r_state;
    w_count_d   = r_count;
    w_timer_d   = r_timer;
    w_timeout_d = 1'b0;
    w_overrun_d = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_idx    = '0;
    unique case (r_state)
      StIdle: begin
        if (i_Rx_DV) begin
          w_wr_en   = 1'b1;
          w_count_d = CW'(1);
          w_timer_d = '0;
          w_state_d = StFill;
        end
      end
      StFill: begin
        if (i_Rx_DV) begin
          // A byte on the last timer cycle still counts; it wins over the timeout.
          w_wr_en   = 1'b1;
          w_wr_idx  = r_count;
          w_count_d = r_count + CW'(1);
          w_timer_d = '0;
          if (r_count == CW'(BLOCK_BYTES - 1)) w_state_d = StFull;
        end else if (r_timer == TW'(TIMEOUT_CLKS - 1)) begin
          w_state_d   = StIdle;
          w_count_d   = '0;
          w_timer_d   = '0;
          w_timeout_d = 1'b1;
        end else begin
          w_timer_d = r_timer + TW'(1);
        end
      end
      StFull: begin
        // r_valid is high throughout StFull, so ready alone completes the handshake.
        if (i_Block_Ready) begin
          w_timer_d = '0;
          if (i_Rx_DV) begin
            w_wr_en   = 1'b1;
            w_count_d = CW'(1);
            w_state_d = StFill;
          end else begin
            w_count_d = '0;
            w_state_d = StIdle;
          end
        end else if (i_Rx_DV) begin
          w_overrun_d = 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_count_d = '0;
        w_timer_d = '0;
      end
    endcase
  end

  // Byte lane write into the block image.
  always_comb begin
    w_block_d = r_block;
    for (int k = 0; k < int'(BLOCK_BYTES); k++) begin
      if (w_wr_en && (w_wr_idx == CW'(k))) w_block_d[k*8 +: 8] = i_Rx_Byte;
    end
  end

  // Registers: reset clears everything, clear flushes state but keeps the block image.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_timer   <= '0;
      r_block   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else if (i_Clear) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_timer   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_count   <= w_count_d;
      r_timer   <= w_timer_d;
      r_block   <= w_block_d;
      r_valid   <= (w_state_d == StFull);
      r_timeout <= w_timeout_d;
      r_overrun <= w_overrun_d;
    end
  end

  assign o_Block_Valid = r_valid;
  assign o_Block       = r_block;
  assign o_Byte_Count  = r_count;
  assign o_Timeout     = r_timeout;
  assign o_Overrun     = r_overrun;

endmodule

// File: tb/tb_aes_block_assembler.sv
// Testbench for aes_block_assembler: directed scenarios plus random traffic,
// checked against a byte-queue reference model.
module tb_aes_block_assembler;

  localparam int unsigned NB = 16;
  localparam int unsigned T  = 3480;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0, clear = 1'b0, dv = 1'b0, ready = 1'b0;
  logic [7:0]   rx = 8'h00;
  logic         valid, tmo, ovr;
  logic [0:127] blk;
  logic [4:0]   cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: bytes of the partial block, plus the block being offered.
  byte unsigned q[$];
  bit           holding;
  logic [0:127] m_blk;
  int           idle;
  bit           e_tmo, e_ovr;
  int           n_tmo, n_ovr, n_valid;

  logic [7:0] vec1 [16] = '{8'h32, 8'h43, 8'hf6, 8'ha8, 8'h88, 8'h5a, 8'h30, 8'h8d,
                            8'h31, 8'h31, 8'h98, 8'ha2, 8'he0, 8'h37, 8'h07, 8'h34};
  logic [127:0] exp1 = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 clk = ~clk;

  aes_block_assembler #(.BLOCK_BYTES(NB), .TIMEOUT_CLKS(T)) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_Clear       (clear),
    .i_Rx_DV       (dv),
    .i_Rx_Byte     (rx),
    .o_Block_Valid (valid),
    .i_Block_Ready (ready),
    .o_Block       (blk),
    .o_Byte_Count  (cnt),
    .o_Timeout     (tmo),
    .o_Overrun     (ovr)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the specified behaviour, using the inputs present at the edge.
  function automatic void model_step();
    e_tmo = 1'b0;
    e_ovr = 1'b0;
    if (!rst_n) begin
      q.delete(); holding = 1'b0; m_blk = '0; idle = 0;
    end else if (clear) begin
      q.delete(); holding = 1'b0; idle = 0;
    end else if (holding) begin
      if (ready) begin
        holding = 1'b0;
        idle = 0;
        if (dv) q.push_back(rx);
      end else if (dv) begin
        e_ovr = 1'b1;
      end
    end else if (dv) begin
      q.push_back(rx);
      idle = 0;
      if (q.size() == NB) begin
        for (int k = 0; k < NB; k++) m_blk[k*8 +: 8] = q[k];
        q.delete();
        holding = 1'b1;
      end
    end else if (q.size() > 0) begin
      if (idle == T - 1) begin
        q.delete(); idle = 0; e_tmo = 1'b1;
      end else begin
        idle++;
      end
    end
  endfunction

  task automatic step();
    int ec;
    @(posedge clk);
    model_step();
    #1;
    ec = holding ? NB : q.size();
    chk("valid", 128'(valid), 128'(holding));
    chk("count", 128'(cnt), 128'(ec));
    chk("timeout", 128'(tmo), 128'(e_tmo));
    chk("overrun", 128'(ovr), 128'(e_ovr));
    if (holding) chk("block", blk, m_blk);
    n_tmo   += int'(tmo);
    n_ovr   += int'(ovr);
    n_valid += int'(valid);
  endtask

  task automatic send(input logic [7:0] b);
    dv = 1'b1; rx = b;
    step();
    dv = 1'b0;
  endtask

  task automatic send_vec1();
    for (int i = 0; i < NB; i++) send(vec1[i]);
  endtask

  initial begin
    // Reset state.
    rst_n = 1'b0;
    step(); step();
    chk("rst_block", blk, '0);
    chk("rst_valid", 128'(valid), 0);
    rst_n = 1'b1;
    step();

    // 1: nominal block with ready held high.
    ready = 1'b1; n_valid = 0;
    send_vec1();
    chk("t1_block", blk, exp1);
    chk("t1_valid_up", 128'(valid), 1);
    step();
    chk("t1_valid_down", 128'(valid), 0);
    chk("t1_count0", 128'(cnt), 0);
    chk("t1_valid_cycles", 128'(n_valid), 1);

    // 2: backpressure and overrun.
    ready = 1'b0; n_ovr = 0;
    send_vec1();
    repeat (100) step();
    send(8'haa);
    repeat (99) step();
    chk("t2_overrun_once", 128'(n_ovr), 1);
    chk("t2_block_kept", blk, exp1);
    ready = 1'b1;
    step();
    chk("t2_transferred", 128'(valid), 0);

    // 3: timeout discards a partial block, then a clean block follows.
    n_tmo = 0;
    for (int i = 0; i < 5; i++) send(vec1[i]);
    repeat (T) step();
    chk("t3_timeout_once", 128'(n_tmo), 1);
    chk("t3_count0", 128'(cnt), 0);
    send_vec1();
    chk("t3_block", blk, exp1);
    step();

    // 4: byte on the last timer cycle is accepted; one cycle later it is not.
    n_tmo = 0;
    send(8'h11);
    repeat (T - 1) step();
    send(8'h22);
    chk("t4_edge_accept", 128'(cnt), 2);
    chk("t4_edge_no_tmo", 128'(n_tmo), 0);
    repeat (T) step();
    chk("t4_late_tmo", 128'(n_tmo), 1);
    send(8'h33);
    chk("t4_new_block", 128'(cnt), 1);
    repeat (T) step();

    // 5: handshake and new byte on the same cycle.
    ready = 1'b0;
    send_vec1();
    chk("t5_full", blk, exp1);
    ready = 1'b1;
    send(8'h2b);
    chk("t5_valid_down", 128'(valid), 0);
    chk("t5_count1", 128'(cnt), 1);
    chk("t5_byte0", 128'(blk[0:7]), 128'h2b);
    repeat (T) step();

    // 6: reset mid-fill, then clear mid-fill.
    for (int i = 0; i < 8; i++) send(vec1[i]);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_count", 128'(cnt), 0);
    chk("t6_rst_block", blk, '0);
    send_vec1();
    chk("t6_rst_after", blk, exp1);
    step();
    for (int i = 0; i < 8; i++) send(vec1[i]);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t6_clr_count", 128'(cnt), 0);
    chk("t6_clr_keep", 128'(blk[0:63]), 128'h3243f6a8885a308d);
    send_vec1();
    chk("t6_clr_after", blk, exp1);
    step();

    // Random traffic with random backpressure and occasional clears.
    for (int i = 0; i < 800; i++) begin
      dv    = ($urandom_range(2) != 0);
      rx    = 8'($urandom);
      ready = ($urandom_range(3) == 0);
      clear = ($urandom_range(199) == 0);
      step();
    end
    dv = 1'b0; clear = 1'b0; ready = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
